uart_rx_mv: RTL and testbench
=============================

// Module: uart_rx_mv
// PURPOSE
//  Parametrised, next-generation UART receiver with majority-vote mid-bit sampling.
//  Configurable oversampling ratio and frame format, on-chip input synchroniser,
//  valid/ready output holding register, and per-frame error status.
//  Sits between the async pad input and the bus-side RX FIFO, on the rx_clk (oversample) domain.
// PARAMETERS
//  OVERSAMPLE   16  rx_clk cycles per bit; even, >= 8
//  MAX_DATA     9   maximum data bits per frame (5..9); sets rx_data width
//  SYNC_STAGES  2   flops in the rx input synchroniser (>= 2)
// PORTS
//  rx_clk       in   1         oversample clock
//  rst          in   1         asynchronous reset, active-low
//  rx_en        in   1         enable start-bit detection
//  rx           in   1         serial input, asynchronous, idle high
//  parity_en    in   1         1 = frame carries a parity bit
//  parity_type  in   1         1 = odd parity, 0 = even parity
//  data_len     in   4         data bits per frame, 5..MAX_DATA
//  stop2        in   1         1 = two stop bits checked
//  rx_data      out  MAX_DATA  received word, LSB first on wire, right-justified, upper bits 0
//  rx_valid     out  1         rx_data and status flags valid
//  rx_ready     in   1         consumer accepts word when rx_valid && rx_ready
//  parity_err   out  1         status of held word: parity mismatch
//  frame_err    out  1         status of held word: a stop bit sampled low
//  break_det    out  1         status of held word: line low through whole frame
//  overrun      out  1         1-cycle pulse: frame completed while previous word unaccepted
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchroniser flops preset to 1.
//  rx passes through SYNC_STAGES flops; rxs denotes the synchronised value.
//  Sample: majority of rxs at bit counts H-1, H, H+1 (H = OVERSAMPLE/2), decided at H+1.
//  Config (parity_en, parity_type, data_len, stop2) is latched at start detection.
//  data_len < 5 is treated as 5; data_len > MAX_DATA is treated as MAX_DATA.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE | WAIT_IDLE.
//   IDLE: rx_en && rxs == 0 -> START, bit counter = 1.
//   START: vote == 1 at H+1 -> false start, back to IDLE, no flags, no rx_valid.
//   Each bit period ends at count OVERSAMPLE-1, after which the counter wraps to 0.
//   DATA: shifts in data_len bits, LSB first. PARITY: checked against the data bits.
//   STOP1/STOP2: frame completes at the H+1 vote of the final stop bit, not at the bit end.
//    This allows a back-to-back start edge to be caught.
//  Completion: rx_valid rises the cycle after the final stop vote; flags are registered with rx_data.
//   parity_err = parity_en && mismatch; frame_err = any stop vote 0.
//   break_det = all data, parity and stop votes 0; it implies frame_err = 1 and rx_data = 0.
//   After a break: WAIT_IDLE until rxs == 1, then IDLE.
//  Handshake: rx_valid holds, with data and flags stable, until a cycle with rx_ready = 1.
//   Accept with no new completion: rx_valid falls next cycle.
//   Accept and completion in the same cycle: new word loads and rx_valid stays 1.
//   Completion while rx_valid && !rx_ready: overrun pulses 1 cycle; the new frame is discarded.
//  rx_en deasserted mid-frame: the current frame completes normally.
//  rst mid-frame: immediate return to reset values; the partial frame is lost.
// TESTING
//  OS=16, 8N1, 0xA5 -> rx_valid 1 cycle after the final stop vote.
//   rx_data=0x0A5, all flags 0; rx_valid holds until rx_ready.
//  7E2, 0x3C, correct parity -> rx_data=0x03C, parity_err=0.
//   Flip the parity bit -> parity_err=1, word still delivered.
//  8N1, stop bit driven low -> frame_err=1.
//   Line low for 12 bit times -> break_det=1, rx_data=0, no second start until rx returns high.
//  1-bit-time/4 low glitch on idle line -> busy pulses, no rx_valid, no flags.
//   Single-sample spike inside a data bit -> vote unaffected.
//  Two back-to-back frames with rx_ready=0 -> first word retained, overrun pulses once.
//   Same frames with rx_ready=1 -> both words delivered.
//  9-bit data 0x1FF, OVERSAMPLE=8 build -> rx_data=0x1FF.
//   rst asserted mid-DATA -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx_mv.sv
// UART receiver with three-sample majority vote at mid-bit, input synchroniser,
// valid/ready holding register and per-frame parity/frame/break status.
//
// state     | meaning
// S_IDLE    | waiting for a low level on the synchronised line
// S_START   | start bit; a high vote aborts as a false start
// S_DATA    | shifting in data bits, LSB first
// S_PARITY  | sampling the parity bit
// S_STOP1   | first stop bit; frame completes here when stop2 = 0
// S_STOP2   | second stop bit
// S_WAIT_IDLE | after a break, hold off until the line returns high
module uart_rx_mv #(
  parameter int OVERSAMPLE  = 16,
  parameter int MAX_DATA    = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rx_clk,
  input  logic                rst,
  input  logic                rx_en,
  input  logic                rx,
  input  logic                parity_en,
  input  logic                parity_type,
  input  logic [3:0]          data_len,
  input  logic                stop2,
  output logic [MAX_DATA-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun,
  output logic                busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_VOTE = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_END  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_nxt;
  logic [1:0]              samp_q, samp_d;
  logic [3:0]              bit_idx_q, bit_idx_d, len_q, len_d, len_clamp;
  logic                    pen_q, pen_d, podd_q, podd_d, st2_q, st2_d;
  logic [MAX_DATA-1:0]     shift_q, shift_d, data_q, data_d;
  logic                    par_q, par_d, any_one_q, any_one_d, stop_bad_q, stop_bad_d;
  logic                    valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                    brk_q, brk_d, ovr_q, ovr_d;
  logic                    rxs, vote, mid, bit_end, complete;
  logic                    fin_ferr, fin_brk, fin_perr;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
  assign samp_d  = {samp_q[0], rxs};
  // samp_q holds the two samples preceding the current one, so at C_VOTE this is H-1, H, H+1
  assign vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
  assign mid     = (cnt_q == C_VOTE);
  assign bit_end = (cnt_q == C_END);
  assign cnt_nxt = bit_end ? '0 : cnt_q + CW'(1);

  assign fin_ferr = stop_bad_q | ~vote;
  assign fin_brk  = ~(any_one_q | vote);
  assign fin_perr = pen_q & (par_q != ((^shift_q) ^ podd_q));

  always_comb begin
    len_clamp = data_len;
    if (data_len < 4'd5) len_clamp = 4'd5;
    else if (data_len > 4'(MAX_DATA)) len_clamp = 4'(MAX_DATA);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    len_d      = len_q;
    pen_d      = pen_q;
    podd_d     = podd_q;
    st2_d      = st2_q;
    shift_d    = shift_q;
    par_d      = par_q;
    any_one_d  = any_one_q;
    stop_bad_d = stop_bad_q;
    complete   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_en && !rxs) begin
          state_d    = S_START;
          cnt_d      = CW'(1);
          bit_idx_d  = '0;
          len_d      = len_clamp;
          pen_d      = parity_en;
          podd_d     = parity_type;
          st2_d      = stop2;
          shift_d    = '0;
          par_d      = 1'b0;
          any_one_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      S_START: begin
        cnt_d = cnt_nxt;
        if (mid && vote) state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = cnt_nxt;
        if (mid) begin
          shift_d   = shift_q | (MAX_DATA'(vote) << bit_idx_q);
          any_one_d = any_one_q | vote;
        end
        if (bit_end) begin
          if (bit_idx_q == len_q - 4'd1) state_d = pen_q ? S_PARITY : S_STOP1;
          else bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      S_PARITY: begin
        cnt_d = cnt_nxt;
        if (mid) begin
          par_d     = vote;
          any_one_d = any_one_q | vote;
        end
        if (bit_end) state_d = S_STOP1;
      end
      S_STOP1: begin
        cnt_d = cnt_nxt;
        if (mid) begin
          stop_bad_d = ~vote;
          any_one_d  = any_one_q | vote;
          complete   = ~st2_q;
        end
        if (bit_end) state_d = S_STOP2;
      end
      S_STOP2: begin
        cnt_d = cnt_nxt;
        if (mid) complete = 1'b1;
      end
      S_WAIT_IDLE: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // completing at the stop-bit vote leaves half a bit to catch a back-to-back start
    if (complete) state_d = fin_brk ? S_WAIT_IDLE : S_IDLE;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    ovr_d   = 1'b0;
    if (complete && valid_q && !rx_ready) begin
      ovr_d = 1'b1;
    end else if (complete) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      perr_d  = fin_perr;
      ferr_d  = fin_ferr;
      brk_d   = fin_brk;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      cnt_q      <= '0;
      samp_q     <= '1;
      bit_idx_q  <= '0;
      len_q      <= 4'd5;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      st2_q      <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      any_one_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      len_q      <= len_d;
      pen_q      <= pen_d;
      podd_q     <= podd_d;
      st2_q      <= st2_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      any_one_q  <= any_one_d;
      stop_bad_q <= stop_bad_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed bench for uart_rx_mv: default build (OS=16) plus an OVERSAMPLE=8 build.
module tb_uart_rx_mv;
  logic       rx_clk = 1'b0;
  logic       rst, rx_en, rx, rx8, parity_en, parity_type, stop2, rx_ready;
  logic [3:0] data_len;
  logic [8:0] rx_data, rx_data8;
  logic       rx_valid, parity_err, frame_err, break_det, overrun, busy;
  logic       rx_valid8, perr8, ferr8, brk8, ovr8, busy8;

  int checks = 0, errors = 0;
  int cyc = 0, rise_cyc = -1, ov_cnt = 0;
  bit busy_seen = 0, prev_valid = 0;
  logic [8:0] got[$];

  always #5 rx_clk = ~rx_clk;

  uart_rx_mv dut (
    .rx_clk(rx_clk), .rst(rst), .rx_en(rx_en), .rx(rx),
    .parity_en(parity_en), .parity_type(parity_type), .data_len(data_len), .stop2(stop2),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .busy(busy));

  uart_rx_mv #(.OVERSAMPLE(8)) dut8 (
    .rx_clk(rx_clk), .rst(rst), .rx_en(rx_en), .rx(rx8),
    .parity_en(parity_en), .parity_type(parity_type), .data_len(data_len), .stop2(stop2),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready),
    .parity_err(perr8), .frame_err(ferr8), .break_det(brk8),
    .overrun(ovr8), .busy(busy8));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake capture uses the values that the coming posedge will see.
  task automatic tick();
    if (rx_valid && rx_ready) got.push_back(rx_data);
    @(negedge rx_clk);
    cyc++;
    if (overrun) ov_cnt++;
    if (busy) busy_seen = 1;
    if (rx_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = rx_valid;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  function automatic logic [15:0] mkf(input logic [8:0] d, input int len, input bit pen,
                                      input bit podd, input bit pflip, input bit s1, input bit s2);
    logic [15:0] f;
    logic par;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    par = podd;
    for (int i = 0; i < len; i++) begin
      f[k[3:0]] = d[i[3:0]];
      par = par ^ d[i[3:0]];
      k++;
    end
    if (pen) begin
      f[k[3:0]] = par ^ pflip;
      k++;
    end
    f[k[3:0]] = s1;
    k++;
    f[k[3:0]] = s2;
    return f;
  endfunction

  // Drives nb bits of f, os cycles each; optional one-cycle inversion at (sb, so).
  task automatic send(input logic [15:0] f, input int nb, input int os, input bit to8,
                      input int sb, input int so);
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < os; j++) begin
        logic v;
        v = f[i[3:0]] ^ ((i == sb) && (j == so));
        if (to8) rx8 = v; else rx = v;
        tick();
      end
    end
    if (to8) rx8 = 1'b1; else rx = 1'b1;
  endtask

  initial begin
    rx = 1'b1; rx8 = 1'b1; rst = 1'b0; rx_en = 1'b1; rx_ready = 1'b0;
    parity_en = 1'b0; parity_type = 1'b0; data_len = 4'd8; stop2 = 1'b0;
    idle(3);
    check("reset_flags", {rx_valid, parity_err, frame_err, break_det, overrun, busy}, 0);
    check("reset_data", rx_data, 0);
    rst = 1'b1;
    idle(5);

    // 8N1 0xA5: valid appears one cycle after the final stop vote
    cyc = 0; rise_cyc = -1; prev_valid = rx_valid;
    send(mkf(9'h0A5, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    check("t1_latency", 16'(rise_cyc), 156);
    check("t1_data", rx_data, 16'h0A5);
    check("t1_flags", {parity_err, frame_err, break_det}, 0);
    idle(20);
    check("t1_hold_valid", rx_valid, 1);
    check("t1_hold_data", rx_data, 16'h0A5);
    accept();
    check("t1_accept", rx_valid, 0);

    // quarter-bit glitch on the idle line
    busy_seen = 0; ov_cnt = 0;
    rx = 1'b0; idle(4); rx = 1'b1; idle(40);
    check("glitch_busy", busy_seen, 1);
    check("glitch_valid", rx_valid, 0);
    check("glitch_flags", {parity_err, frame_err, break_det, 1'b0}, 0);
    check("glitch_ovr", 16'(ov_cnt), 0);

    // single-sample spike in the middle of data bit 0
    send(mkf(9'h0A5, 8, 0, 0, 0, 1, 1), 10, 16, 0, 1, 8);
    check("spike_data", rx_data, 16'h0A5);
    check("spike_ferr", frame_err, 0);
    accept();

    // 7E2 / 7O2 parity
    parity_en = 1'b1; parity_type = 1'b0; data_len = 4'd7; stop2 = 1'b1;
    send(mkf(9'h03C, 7, 1, 0, 0, 1, 1), 11, 16, 0, -1, -1);
    check("7e2_data", rx_data, 16'h03C);
    check("7e2_perr", parity_err, 0);
    check("7e2_ferr", frame_err, 0);
    accept();
    send(mkf(9'h03C, 7, 1, 0, 1, 1, 1), 11, 16, 0, -1, -1);
    check("7e2_flip_valid", rx_valid, 1);
    check("7e2_flip_perr", parity_err, 1);
    check("7e2_flip_data", rx_data, 16'h03C);
    accept();
    parity_type = 1'b1;
    send(mkf(9'h03C, 7, 1, 1, 0, 1, 1), 11, 16, 0, -1, -1);
    check("7o2_perr", parity_err, 0);
    accept();
    parity_type = 1'b0;
    send(mkf(9'h03C, 7, 1, 0, 0, 1, 0), 11, 16, 0, -1, -1);
    idle(30);
    check("stop2_low_ferr", frame_err, 1);
    check("stop2_low_perr", parity_err, 0);
    accept();

    // 8N1 with the stop bit low
    parity_en = 1'b0; data_len = 4'd8; stop2 = 1'b0;
    send(mkf(9'h055, 8, 0, 0, 0, 0, 1), 10, 16, 0, -1, -1);
    idle(30);
    check("stop_low_ferr", frame_err, 1);
    check("stop_low_data", rx_data, 16'h055);
    check("stop_low_brk", break_det, 0);
    accept();

    // line low for 12 bit times
    ov_cnt = 0;
    send(16'h0000, 12, 16, 0, -1, -1);
    check("break_wait_busy", busy, 1);
    idle(10);
    check("break_idle_busy", busy, 0);
    check("break_valid", rx_valid, 1);
    check("break_flags", {parity_err, frame_err, break_det}, 3'b011);
    check("break_data", rx_data, 0);
    accept();
    idle(200);
    check("break_no_second", rx_valid, 0);
    check("break_no_ovr", 16'(ov_cnt), 0);

    // back-to-back frames with no consumer
    ov_cnt = 0;
    send(mkf(9'h011, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    send(mkf(9'h022, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    idle(5);
    check("ovr_data", rx_data, 16'h011);
    check("ovr_valid", rx_valid, 1);
    check("ovr_pulses", 16'(ov_cnt), 1);
    accept();

    // back-to-back frames with consumer always ready
    got.delete(); ov_cnt = 0; rx_ready = 1'b1;
    send(mkf(9'h033, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    send(mkf(9'h044, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    idle(5);
    rx_ready = 1'b0;
    check("b2b_count", 16'(got.size()), 2);
    check("b2b_first", (got.size() > 0) ? 16'(got[0]) : 16'hFFFF, 16'h033);
    check("b2b_second", (got.size() > 1) ? 16'(got[1]) : 16'hFFFF, 16'h044);
    check("b2b_ovr", 16'(ov_cnt), 0);

    // data_len clamping
    data_len = 4'd15;
    send(mkf(9'h155, 9, 0, 0, 0, 1, 1), 11, 16, 0, -1, -1);
    check("len_hi_clamp", rx_data, 16'h155);
    accept();
    data_len = 4'd3;
    send(mkf(9'h015, 5, 0, 0, 0, 1, 1), 7, 16, 0, -1, -1);
    check("len_lo_clamp", rx_data, 16'h015);
    accept();

    // OVERSAMPLE=8 build, 9 data bits
    data_len = 4'd9;
    send(mkf(9'h1FF, 9, 0, 0, 0, 1, 1), 11, 8, 1, -1, -1);
    idle(5);
    check("os8_valid", rx_valid8, 1);
    check("os8_data", rx_data8, 16'h1FF);
    check("os8_ferr", ferr8, 0);

    // rx_en low ignores the line
    data_len = 4'd8; rx_en = 1'b0; busy_seen = 0;
    send(mkf(9'h066, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    check("rxen_valid", rx_valid, 0);
    check("rxen_busy", busy_seen, 0);
    rx_en = 1'b1;

    // reset in the middle of DATA with a word held
    send(mkf(9'h077, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    check("pre_rst_valid", rx_valid, 1);
    send(mkf(9'h099, 8, 0, 0, 0, 1, 1), 4, 16, 0, -1, -1);
    rst = 1'b0;
    tick();
    check("rst_flags", {rx_valid, parity_err, frame_err, break_det, overrun, busy}, 0);
    check("rst_data", rx_data, 0);
    check("rst_os8_valid", rx_valid8, 0);
    idle(2);
    rst = 1'b1;
    idle(5);
    send(mkf(9'h05A, 8, 0, 0, 0, 1, 1), 10, 16, 0, -1, -1);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 16'h05A);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
